// File: rtl/dmem_access_ctrl.sv
// Two-port sequencer/arbiter for the 2K-word data memory: address decode, RMW for sub-word stores.
// Optional macro DMEM_ACCESS_CTRL_STATS_EN adds a saturating error counter output err_cnt.
module dmem_access_ctrl #(
    parameter logic [31:0] GLOBAL_BASE = 32'h10010000,
    parameter logic [31:0] STACK_BASE  = 32'h7FFFEFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ACCESS_CTRL_STATS_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [10:0] phys_q, phys_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    // Round-robin on a tie: the port not granted last time wins.
    logic        sel_port;
    logic [31:0] sel_addr;
    logic        sel_wr;
    logic [1:0]  sel_size;
    logic [31:0] sel_wdata;

    assign sel_port  = req1 & (~req0 | ~last_grant_q);
    assign sel_addr  = sel_port ? addr1  : addr0;
    assign sel_wr    = sel_port ? wr1    : wr0;
    assign sel_size  = sel_port ? size1  : size0;
    assign sel_wdata = sel_port ? wdata1 : wdata0;

    logic        in_global, in_stack, misaligned, bad_access;
    logic [9:0]  global_idx, stack_idx;
    logic [10:0] sel_phys;

    assign in_global  = (sel_addr >= GLOBAL_BASE) && (sel_addr <= GLOBAL_BASE + 32'h0000_0FFF);
    assign in_stack   = (sel_addr >= STACK_BASE)  && (sel_addr <= STACK_BASE  + 32'h0000_0FFF);
    // Both windows are 4 KB, so offsets are exact modulo 4096.
    assign global_idx = 10'((sel_addr[11:0] - GLOBAL_BASE[11:0]) >> 2);
    assign stack_idx  = 10'((sel_addr[11:0] - STACK_BASE[11:0]) >> 2);
    assign sel_phys   = in_global ? {1'b0, global_idx} : {1'b1, stack_idx};
    assign misaligned = (sel_size == 2'b11)
                     || ((sel_size == SZ_HALF) && sel_addr[0])
                     || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
    assign bad_access = misaligned || !(in_global || in_stack);

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, merged, extracted;

    always_comb begin
        case (size_q)
            SZ_BYTE: begin
                lane_be    = 4'b0001 << lane_q;
                lane_wdata = {4{data_q[7:0]}};
                extracted  = {24'b0, mem_rdata[{lane_q, 3'b000} +: 8]};
            end
            SZ_HALF: begin
                lane_be    = lane_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{data_q[15:0]}};
                extracted  = {16'b0, (lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0])};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = data_q;
                extracted  = mem_rdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = lane_be[gi] ? lane_wdata[8*gi +: 8] : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        wr_d         = wr_q;
        size_d       = size_q;
        lane_d       = lane_q;
        phys_d       = phys_q;
        data_d       = data_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    port_d       = sel_port;
                    last_grant_d = sel_port;
                    wr_d         = sel_wr;
                    size_d       = sel_size;
                    lane_d       = sel_addr[1:0];
                    phys_d       = sel_phys;
                    data_d       = sel_wdata;
                    err_d        = bad_access;
                    if (bad_access)
                        state_d = S_ERR;
                    else if (sel_wr && (sel_size == SZ_WORD))
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                data_d  = wr_q ? merged : extracted;
                state_d = wr_q ? S_WRITE : S_DONE;
            end
            S_WRITE: state_d = S_DONE;
            S_ERR: begin
                data_d  = 32'b0;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            phys_q       <= 11'b0;
            data_q       <= 32'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            phys_q       <= phys_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = ((state_q == S_READ) || (state_q == S_WRITE)) ? phys_q : 11'b0;
    assign mem_wdata = (state_q == S_WRITE) ? data_q : 32'b0;
    assign ack0      = (state_q == S_DONE) && !port_q;
    assign ack1      = (state_q == S_DONE) && port_q;
    assign err       = (state_q == S_DONE) && err_q;
    // Store completions return zero data; error completions carry zero in data_q.
    assign rdata     = ((state_q == S_DONE) && !wr_q) ? data_q : 32'b0;

`ifdef DMEM_ACCESS_CTRL_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == S_DONE) && err_q && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= 16'b0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl with an address-map/lane reference model
// and a shadow copy of the data memory.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        ack0, ack1, err, busy, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [10:0] mem_addr;
`ifdef DMEM_ACCESS_CTRL_STATS_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wr0(wr0), .wr1(wr1), .size0(size0), .size1(size1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ACCESS_CTRL_STATS_EN
        , .err_cnt(err_cnt)
`endif
    );

    // Synchronous-read memory plus a preload port used only while the DUT is idle.
    logic [31:0] tb_mem [0:2047];
    logic [31:0] shadow [0:2047];
    logic        pl_we = 1'b0;
    logic [10:0] pl_addr = 11'd0;
    logic [31:0] pl_data = 32'd0;

    always @(posedge clk) begin
        if (pl_we) tb_mem[pl_addr] <= pl_data;
        else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int exp_errs = 0;

    function automatic void model(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                                  output bit bad, output int idx, output int lat);
        bit ok, mis;
        ok  = 1'b1;
        idx = 0;
        if (a >= 32'h10010000 && a <= 32'h10010FFF)      idx = int'((a - 32'h10010000) / 4);
        else if (a >= 32'h7FFFEFFC && a <= 32'h7FFFFFFB) idx = 1024 + int'((a - 32'h7FFFEFFC) / 4);
        else ok = 1'b0;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        bad = !ok || mis;
        if (bad)             lat = 2;
        else if (!wr)        lat = 3;
        else if (sz == 2'b10) lat = 2;
        else                 lat = 4;
    endfunction

    function automatic int lane_shift(input logic [31:0] a, input logic [1:0] sz);
        int k;
        k = int'(a % 4);
        if (sz == 2'b00) return 8 * k;
        if (sz == 2'b01) return (k >= 2) ? 16 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        if (sz == 2'b00) return 32'h0000_00FF;
        if (sz == 2'b01) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz);
        return (w >> lane_shift(a, sz)) & lane_mask(sz);
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] a,
                                             input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] m;
        m = lane_mask(sz) << lane_shift(a, sz);
        return (old & ~m) | ((wd << lane_shift(a, sz)) & m);
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        wait_idle();
        pl_we = 1'b1; pl_addr = 11'(idx); pl_data = val;
        shadow[idx] = val;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic run_txn(input int port, input logic [31:0] a, input logic wr,
                           input logic [1:0] sz, input logic [31:0] wd, input string tag);
        bit bad, got_ack;
        int idx, lat, ack_cyc, we_cnt, we_cyc;
        logic [1:0]  ack_v;
        logic        err_v;
        logic [31:0] rdata_v, we_data, exp_word, old;
        logic [10:0] we_addr;
        model(a, wr, sz, bad, idx, lat);
        old = shadow[idx];
        exp_word = wr ? st_merge(old, a, sz, wd) : ld_val(old, a, sz);
        wait_idle();
        if (port == 0) begin req0 = 1; addr0 = a; wr0 = wr; size0 = sz; wdata0 = wd; end
        else           begin req1 = 1; addr1 = a; wr1 = wr; size1 = sz; wdata1 = wd; end
        got_ack = 0; we_cnt = 0; we_cyc = 0; ack_cyc = 0;
        ack_v = 0; err_v = 0; rdata_v = 0; we_data = 0; we_addr = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req0 = 0; req1 = 0;
                n_vec++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b want 1", tag, busy); end
            end
            if (mem_we) begin we_cnt++; we_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
            if (ack0 || ack1) begin
                got_ack = 1; ack_cyc = c; ack_v = {ack1, ack0}; err_v = err; rdata_v = rdata;
                break;
            end
        end
        n_vec++;
        if (!got_ack) begin
            n_err++; $display("FAIL %s timeout: got no ack want ack at cycle %0d", tag, lat);
            return;
        end
        n_vec++;
        if (ack_v !== ((port == 0) ? 2'b01 : 2'b10)) begin
            n_err++; $display("FAIL %s ack_port: got %b want port %0d", tag, ack_v, port);
        end
        n_vec++;
        if (err_v !== bad) begin n_err++; $display("FAIL %s err: got %b want %b", tag, err_v, bad); end
        n_vec++;
        if (ack_cyc != lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, ack_cyc, lat); end
        n_vec++;
        if (we_cnt != ((wr && !bad) ? 1 : 0)) begin
            n_err++; $display("FAIL %s we_count: got %0d want %0d", tag, we_cnt, (wr && !bad) ? 1 : 0);
        end
        if (wr && !bad) begin
            n_vec++;
            if (we_cyc != lat - 1 || we_addr !== 11'(idx) || we_data !== exp_word) begin
                n_err++;
                $display("FAIL %s write: got cyc %0d addr %h data %h want cyc %0d addr %h data %h",
                         tag, we_cyc, we_addr, we_data, lat - 1, 11'(idx), exp_word);
            end
            shadow[idx] = exp_word;
        end else if (!wr || bad) begin
            n_vec++;
            if (rdata_v !== (bad ? 32'h0 : exp_word)) begin
                n_err++; $display("FAIL %s rdata: got %h want %h", tag, rdata_v, bad ? 32'h0 : exp_word);
            end
        end
        if (bad) exp_errs++;
    endtask

    task automatic test_reset();
        rst = 1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; size0 = 0; size1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            pl_we = 1; pl_addr = 11'(i); pl_data = $urandom; shadow[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 0;
        n_vec++;
        if ({ack0, ack1, err, busy, mem_we} !== 5'b0 || rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack %b%b err %b busy %b we %b rdata %h addr %h wdata %h want all 0",
                     ack0, ack1, err, busy, mem_we, rdata, mem_addr, mem_wdata);
        end
`ifdef DMEM_ACCESS_CTRL_STATS_EN
        n_vec++;
        if (err_cnt !== 16'h0) begin n_err++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
`endif
        rst = 0;
        exp_errs = 0;
    endtask

    task automatic test_directed();
        run_txn(0, 32'h10010008, 1, 2'b10, 32'hDEADBEEF, "p0_word_store");
        preload(2047, 32'h11223344);
        run_txn(0, 32'h7FFFFFFA, 0, 2'b00, 32'h0, "p0_byte_load_lane2");
        run_txn(0, 32'h7FFFFFFB, 0, 2'b00, 32'h0, "p0_byte_load_lane3");
        preload(0, 32'h11223344);
        run_txn(1, 32'h10010001, 1, 2'b00, 32'h000000AB, "p1_byte_store");
        run_txn(1, 32'h10010002, 0, 2'b01, 32'h0, "p1_half_load_hi");
    endtask

    task automatic test_errors();
        run_txn(0, 32'h7FFFFFFC, 0, 2'b10, 32'h0, "err_stack_above");
        run_txn(0, 32'h10010003, 1, 2'b01, 32'h1234, "err_half_misaligned");
        run_txn(1, 32'h7FFFEFFB, 0, 2'b00, 32'h0, "err_stack_below");
        run_txn(1, 32'h10011000, 1, 2'b10, 32'h5, "err_global_above");
        run_txn(0, 32'h10010000, 0, 2'b11, 32'h0, "err_size11");
        run_txn(1, 32'h7FFFEFFC, 0, 2'b10, 32'h0, "stack_first_word");
        run_txn(0, 32'h10010FFC, 1, 2'b10, 32'hCAFEF00D, "global_last_word");
    endtask

    task automatic test_arbitration();
        int order [3];
        int n_ack;
        wait_idle();
        rst = 1; #2; rst = 0;
        exp_errs = 0;
        @(negedge clk);
        req0 = 1; addr0 = 32'h10010010; wr0 = 0; size0 = 2'b10;
        req1 = 1; addr1 = 32'h10010020; wr1 = 0; size1 = 2'b10;
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 3; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) begin order[n_ack] = ack1 ? 1 : 0; n_ack++; end
        end
        req0 = 0; req1 = 0;
        n_vec++;
        if (n_ack != 3) begin
            n_err++; $display("FAIL arb_timeout: got %0d acks want 3", n_ack);
        end else begin
            n_vec++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
                n_err++; $display("FAIL arb_order: got %0d,%0d,%0d want 0,1,0", order[0], order[1], order[2]);
            end
        end
    endtask

    task automatic test_reset_midway();
        int we_cnt, ack_cyc, pre_bad;
        logic [31:0] wd, exp_word;
        logic [10:0] we_addr;
        logic [31:0] we_data;
        wd = $urandom;
        exp_word = st_merge(shadow[64], 32'h10010102, 2'b00, wd);
        wait_idle();
        req0 = 1; addr0 = 32'h10010102; wr0 = 1; size0 = 2'b00; wdata0 = wd;
        we_cnt = 0; pre_bad = 0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            if (mem_we || ack0 || ack1) pre_bad++;
        end
        #2; rst = 1; #1;
        exp_errs = 0;
        n_vec++;
        if (pre_bad != 0 || {ack0, ack1, err, busy, mem_we} !== 5'b0 || rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            n_err++;
            $display("FAIL midreset_outputs: got pre %0d ack %b%b busy %b we %b addr %h want all 0",
                     pre_bad, ack0, ack1, busy, mem_we, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (tb_mem[64] !== shadow[64]) begin
            n_err++; $display("FAIL midreset_mem: got %h want %h", tb_mem[64], shadow[64]);
        end
        rst = 0;
        ack_cyc = 0; we_addr = 0; we_data = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) req0 = 0;
            if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
            if (ack0 || ack1) begin ack_cyc = ack0 ? c : -c; break; end
        end
        n_vec++;
        if (ack_cyc != 4 || we_cnt != 1 || we_addr !== 11'd64 || we_data !== exp_word) begin
            n_err++;
            $display("FAIL midreset_replay: got ack_cyc %0d we %0d addr %h data %h want 4 1 040 %h",
                     ack_cyc, we_cnt, we_addr, we_data, exp_word);
        end
        shadow[64] = exp_word;
    endtask

    task automatic test_random();
        logic [31:0] edges [9];
        logic [31:0] a;
        edges = '{32'h10010000, 32'h10010FFF, 32'h1000FFFF, 32'h10011000, 32'h7FFFEFFC,
                  32'h7FFFEFFB, 32'h7FFFFFFB, 32'h7FFFFFFC, 32'h7FFFEFFD};
        for (int t = 0; t < 160; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h10010000 + $urandom_range(0, 32'hFFF);
                1:       a = 32'h7FFFEFFC + $urandom_range(0, 32'hFFF);
                2:       a = edges[$urandom_range(0, 8)];
                default: a = $urandom;
            endcase
            run_txn(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom, $sformatf("rand%0d", t));
        end
    endtask

    task automatic test_final_state();
        int bad_words;
        wait_idle();
        bad_words = 0;
        for (int i = 0; i < 2048; i++) if (tb_mem[i] !== shadow[i]) bad_words++;
        n_vec++;
        if (bad_words != 0) begin n_err++; $display("FAIL mem_image: got %0d differing words want 0", bad_words); end
`ifdef DMEM_ACCESS_CTRL_STATS_EN
        n_vec++;
        if (err_cnt !== 16'(exp_errs)) begin
            n_err++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_errs);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_arbitration();
        test_reset_midway();
        test_random();
        test_final_state();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
